// File: rtl/adpll_cfg_seq.sv
// ADPLL configuration sequencer: programs FCW, mode and enable over the adpll_ctr CPU bus,
// polls for lock, then serialises TX bytes MSB first onto data_mod.
module adpll_cfg_seq #(
  parameter int                FCWW      = 26,
  parameter int                BIT_CYC   = 32,
  parameter int                POLL_GAP  = 16,
  parameter int                LOCK_TMO  = 1024,
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] ADDR_FCW  = 8'h04,
  parameter logic [ADDR_W-1:0] ADDR_MODE = 8'h08,
  parameter logic [ADDR_W-1:0] ADDR_EN   = 8'h0C,
  parameter logic [ADDR_W-1:0] ADDR_LOCK = 8'h10,
  parameter logic [1:0]        MODE_TX   = 2'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [FCWW-1:0]   fcw,
  input  logic [1:0]        mode,
  output logic              valid,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wdata,
  output logic              wstrb,
  input  logic [1:0]        rdata,
  input  logic              ready,
  input  logic [7:0]        tx_byte,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              data_mod,
  output logic              busy,
  output logic              locked,
  output logic              tmo_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_FCW  = 3'd1;
  localparam logic [2:0] S_WR_MODE = 3'd2;
  localparam logic [2:0] S_WR_EN   = 3'd3;
  localparam logic [2:0] S_RD_LOCK = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;
  localparam logic [2:0] S_RUN     = 3'd6;
  localparam logic [2:0] S_WR_DIS  = 3'd7;

  localparam int PW = $clog2(LOCK_TMO + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int TW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  localparam logic [PW-1:0] POLL_LAST = PW'(LOCK_TMO - 1);
  localparam logic [PW-1:0] POLL_MAX  = PW'(LOCK_TMO);
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);
  localparam logic [TW-1:0] TIM_LAST  = TW'(BIT_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [FCWW-1:0]   fcw_q, fcw_d;
  logic [1:0]        mode_q, mode_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wstrb_q, wstrb_d;
  logic              stop_q, stop_d;
  logic              locked_q, locked_d;
  logic              tmo_err_q, tmo_err_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [2:0]        bit_q, bit_d;
  logic              active_q, active_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic [ADDR_W-1:0] xfer_addr;
  logic [DATA_W-1:0] xfer_data;
  logic              xfer_wr;
  logic              go_dis;
  logic              tx_run;
  logic              bit_last;
  logic              rdata_unused;

  assign rdata_unused = rdata[1];

  // Address/data/direction of the bus transfer owned by the current state.
  always_comb begin
    xfer_addr = ADDR_FCW;
    xfer_data = DATA_W'(fcw_q);
    xfer_wr   = 1'b1;
    case (state_q)
      S_WR_MODE: begin
        xfer_addr = ADDR_MODE;
        xfer_data = DATA_W'(mode_q);
      end
      S_WR_EN: begin
        xfer_addr = ADDR_EN;
        xfer_data = DATA_W'(1'b1);
      end
      S_RD_LOCK: begin
        xfer_addr = ADDR_LOCK;
        xfer_data = '0;
        xfer_wr   = 1'b0;
      end
      S_WR_DIS: begin
        xfer_addr = ADDR_EN;
        xfer_data = '0;
      end
      default: ;
    endcase
  end

  assign tx_run   = (state_q == S_RUN) && (mode_q == MODE_TX) && !stop_q;
  assign bit_last = (bit_q == 3'd7) && (timer_q == TIM_LAST);
  assign tx_ready = tx_run && (!active_q || bit_last);
  assign data_mod = active_q & shreg_q[7];

  assign valid   = valid_q;
  assign address = address_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign locked  = locked_q;
  assign tmo_err = tmo_err_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_RUN);

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d   = state_q;
    fcw_d     = fcw_q;
    mode_d    = mode_q;
    valid_d   = valid_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    locked_d  = locked_q;
    tmo_err_d = tmo_err_q;
    poll_d    = poll_q;
    gap_d     = gap_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    active_d  = active_q;
    timer_d   = timer_q;
    go_dis    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          fcw_d     = fcw;
          mode_d    = mode;
          tmo_err_d = 1'b0;
          poll_d    = '0;
          state_d   = S_WR_FCW;
        end
      end
      S_WR_FCW, S_WR_MODE, S_WR_EN, S_RD_LOCK, S_WR_DIS: begin
        // A pending stop is honoured only between transfers, never while valid is high.
        if (!valid_q) begin
          if (stop_q && (state_q != S_WR_DIS)) begin
            go_dis = 1'b1;
          end else begin
            valid_d   = 1'b1;
            address_d = xfer_addr;
            wdata_d   = xfer_data;
            wstrb_d   = xfer_wr;
          end
        end else if (ready) begin
          valid_d = 1'b0;
          case (state_q)
            S_WR_FCW:  if (stop_q) go_dis = 1'b1; else state_d = S_WR_MODE;
            S_WR_MODE: if (stop_q) go_dis = 1'b1; else state_d = S_WR_EN;
            S_WR_EN:   if (stop_q) go_dis = 1'b1; else state_d = S_RD_LOCK;
            S_RD_LOCK: begin
              if (rdata[0]) begin
                if (stop_q) begin
                  go_dis = 1'b1;
                end else begin
                  state_d  = S_RUN;
                  locked_d = 1'b1;
                end
              end else begin
                if (poll_q != POLL_MAX) poll_d = poll_q + 1'b1;
                if (poll_q == POLL_LAST) begin
                  tmo_err_d = 1'b1;
                  go_dis    = 1'b1;
                end else if (stop_q) begin
                  go_dis = 1'b1;
                end else begin
                  state_d = S_GAP;
                  gap_d   = '0;
                end
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_GAP: begin
        if (stop_q) begin
          go_dis = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_RD_LOCK;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_RUN: begin
        if (stop_q) go_dis = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_dis) begin
      state_d  = S_WR_DIS;
      locked_d = 1'b0;
    end

    stop_d = ((state_q == S_IDLE) || (state_q == S_WR_DIS)) ? 1'b0 : (stop_q | stop);

    // Serialiser: a new byte loads on the last cycle of the previous one for gapless output.
    if (!tx_run) begin
      active_d = 1'b0;
      shreg_d  = '0;
      bit_d    = '0;
      timer_d  = '0;
    end else if (tx_valid && tx_ready) begin
      active_d = 1'b1;
      shreg_d  = tx_byte;
      bit_d    = '0;
      timer_d  = '0;
    end else if (active_q) begin
      if (timer_q == TIM_LAST) begin
        timer_d = '0;
        shreg_d = {shreg_q[6:0], 1'b0};
        if (bit_q == 3'd7) active_d = 1'b0;
        else               bit_d    = bit_q + 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fcw_q     <= '0;
      mode_q    <= '0;
      valid_q   <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 1'b0;
      stop_q    <= 1'b0;
      locked_q  <= 1'b0;
      tmo_err_q <= 1'b0;
      poll_q    <= '0;
      gap_q     <= '0;
      shreg_q   <= '0;
      bit_q     <= '0;
      active_q  <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      fcw_q     <= fcw_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      stop_q    <= stop_d;
      locked_q  <= locked_d;
      tmo_err_q <= tmo_err_d;
      poll_q    <= poll_d;
      gap_q     <= gap_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      active_q  <= active_d;
      timer_q   <= timer_d;
    end
  end

endmodule

// File: tb/tb_adpll_cfg_seq.sv
// Scoreboard bench for adpll_cfg_seq: a bus responder pops expected transfers, a monitor
// pops expected modulation bits.
`timescale 1ns/1ps
module tb_adpll_cfg_seq;

  localparam int         FCWW     = 26;
  localparam int         BIT_CYC  = 32;
  localparam int         POLL_GAP = 16;
  localparam int         LOCK_TMO = 4;
  localparam logic [7:0] A_FCW    = 8'h04;
  localparam logic [7:0] A_MODE   = 8'h08;
  localparam logic [7:0] A_EN     = 8'h0C;
  localparam logic [7:0] A_LOCK   = 8'h10;
  localparam logic [1:0] M_TX     = 2'd1;
  localparam logic [1:0] M_RX     = 2'd2;
  localparam int         FCW_CH   = 2402 * 16384;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        wr;
  } xfer_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stop;
  logic [FCWW-1:0]  fcw;
  logic [1:0]       mode;
  logic             valid;
  logic [7:0]       address;
  logic [31:0]      wdata;
  logic             wstrb;
  logic [1:0]       rdata;
  logic             ready;
  logic [7:0]       tx_byte;
  logic             tx_valid;
  logic             tx_ready;
  logic             data_mod;
  logic             busy, locked, tmo_err;

  xfer_t sb[$];
  bit    exp_bits[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    resp_dly = 2;
  int    lock_on = 0;
  int    rd_count = 0;
  int    last_rd_done = -1;
  int    wait_cnt = 0;
  bit    prev_ready = 1'b0;
  logic [40:0] cap;
  bit    exp_b;
  int    match_n;
  int    quiet_n;

  adpll_cfg_seq #(
    .FCWW(FCWW), .BIT_CYC(BIT_CYC), .POLL_GAP(POLL_GAP), .LOCK_TMO(LOCK_TMO),
    .ADDR_W(8), .DATA_W(32),
    .ADDR_FCW(A_FCW), .ADDR_MODE(A_MODE), .ADDR_EN(A_EN), .ADDR_LOCK(A_LOCK),
    .MODE_TX(M_TX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .fcw(fcw), .mode(mode),
    .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .data_mod(data_mod), .busy(busy), .locked(locked),
    .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_x(input logic [7:0] a, input logic [31:0] d, input logic w);
    xfer_t x;
    x.addr = a;
    x.data = d;
    x.wr   = w;
    sb.push_back(x);
  endtask

  task automatic push_cfg(input logic [1:0] m, input int n_rd);
    push_x(A_FCW, 32'(FCW_CH), 1'b1);
    push_x(A_MODE, {30'd0, m}, 1'b1);
    push_x(A_EN, 32'd1, 1'b1);
    repeat (n_rd) push_x(A_LOCK, 32'd0, 1'b0);
  endtask

  task automatic push_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  task automatic begin_test(input int dly, input int lk);
    resp_dly     = dly;
    lock_on      = lk;
    rd_count     = 0;
    last_rd_done = -1;
  endtask

  task automatic pulse(input logic s, input logic p);
    @(negedge clk);
    start = s;
    stop  = p;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_locked(input string tag, input int lim);
    int i = 0;
    while (i < lim && !locked) begin @(negedge clk); i++; end
    check(tag, i < lim, 1'b1);
  endtask

  task automatic wait_valid(input string tag, input int lim);
    int i = 0;
    while (i < lim && !valid) begin @(negedge clk); i++; end
    check(tag, i < lim, 1'b1);
  endtask

  task automatic wait_txrdy(input string tag, input int lim);
    int i = 0;
    while (i < lim && !tx_ready) begin @(negedge clk); i++; end
    check(tag, i < lim, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int lim);
    int i = 0;
    while (i < lim && (sb.size() != 0 || busy || valid)) begin @(negedge clk); i++; end
    check(tag, i < lim, 1'b1);
  endtask

  // Bus responder: ready after resp_dly sampled cycles, compares each transfer to the scoreboard.
  task automatic responder();
    xfer_t x;
    forever begin
      @(negedge clk);
      if (prev_ready) check("valid_gap", valid, 1'b0);
      prev_ready = 1'b0;
      ready      = 1'b0;
      rdata      = 2'b00;
      if (!valid) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt == 1) begin
          cap = {address, wdata, wstrb};
          if (!wstrb && last_rd_done >= 0)
            check("poll_gap_ok", (cyc - last_rd_done) >= POLL_GAP, 1'b1);
        end
        if (wait_cnt == resp_dly) begin
          check("xfer_stable", {address, wdata, wstrb}, cap);
          if (sb.size() == 0) begin
            check("unexp_xfer", sb.size(), 1);
          end else begin
            x = sb.pop_front();
            check("xfer_addr", address, x.addr);
            check("xfer_wstrb", wstrb, x.wr);
            if (x.wr) check("xfer_wdata", wdata, x.data);
          end
          if (!wstrb) begin
            rd_count++;
            last_rd_done = cyc + 1;
            rdata = (lock_on != 0 && rd_count == lock_on) ? 2'b01 : 2'b00;
          end
          ready      = 1'b1;
          prev_ready = 1'b1;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; fcw = '0; mode = '0;
    tx_byte = '0; tx_valid = 1'b0; ready = 1'b0; rdata = 2'b00;
    fork responder(); join_none

    repeat (3) @(negedge clk);
    check("rst_valid", valid, 1'b0);
    check("rst_wstrb", wstrb, 1'b0);
    check("rst_address", address, 8'h00);
    check("rst_wdata", wdata, 32'h0);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_data_mod", data_mod, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_tmo_err", tmo_err, 1'b0);
    rst = 1'b0;

    // Configure in TX mode, lock on the third poll.
    begin_test(2, 3);
    push_cfg(M_TX, 3);
    fcw = 26'(FCW_CH); mode = M_TX;
    pulse(1'b1, 1'b0);
    check("cfg_busy", busy, 1'b1);
    wait_locked("cfg_lock_to", 2000);
    check("cfg_locked", locked, 1'b1);
    check("cfg_busy_run", busy, 1'b0);
    check("cfg_tmo", tmo_err, 1'b0);
    check("cfg_sb_empty", sb.size(), 0);
    check("cfg_reads", rd_count, 3);

    // Two bytes offered back to back.
    tx_byte = 8'hA5; tx_valid = 1'b1;
    push_bits(8'hA5);
    wait_txrdy("tx_rdy1_to", 50);
    fork
      begin
        @(posedge clk);
        for (int b = 0; b < 16; b++) begin
          exp_b   = exp_bits.pop_front();
          match_n = 0;
          repeat (BIT_CYC) begin
            @(negedge clk);
            if (data_mod === exp_b) match_n++;
          end
          check("dm_bit", match_n, BIT_CYC);
        end
      end
      begin
        @(posedge clk); #1;
        tx_byte = 8'h3C;
        push_bits(8'h3C);
        wait_txrdy("tx_rdy2_to", 300);
        @(posedge clk); #1;
        tx_valid = 1'b0;
      end
    join
    @(negedge clk);
    check("dm_idle", data_mod, 1'b0);
    check("tx_rdy_empty", tx_ready, 1'b1);

    // Stop from RUN disables and returns to IDLE.
    push_x(A_EN, 32'd0, 1'b1);
    pulse(1'b0, 1'b1);
    wait_done("stop_run_to", 200);
    check("stop_run_locked", locked, 1'b0);
    check("stop_run_busy", busy, 1'b0);

    // Start together with stop in IDLE, and stop alone in IDLE, are both ignored.
    pulse(1'b1, 1'b1);
    pulse(1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("ign_ss_busy", busy, 1'b0);
    check("ign_ss_valid", valid, 1'b0);

    // Lock never reported: four polls, timeout, disable.
    begin_test(2, 0);
    push_cfg(M_RX, 4);
    push_x(A_EN, 32'd0, 1'b1);
    mode = M_RX;
    pulse(1'b1, 1'b0);
    wait_done("tmo_to", 1000);
    check("tmo_err_set", tmo_err, 1'b1);
    check("tmo_locked", locked, 1'b0);
    check("tmo_reads", rd_count, LOCK_TMO);

    // Stop while the FCW write waits for a slow ready.
    begin_test(5, 1);
    push_x(A_FCW, 32'(FCW_CH), 1'b1);
    push_x(A_EN, 32'd0, 1'b1);
    mode = M_TX;
    pulse(1'b1, 1'b0);
    check("tmo_cleared", tmo_err, 1'b0);
    wait_valid("slow_valid_to", 20);
    pulse(1'b0, 1'b1);
    wait_done("slow_stop_to", 200);
    check("slow_locked", locked, 1'b0);
    check("slow_busy", busy, 1'b0);

    // RX mode: serialiser stays quiet; start in RUN is ignored.
    begin_test(2, 1);
    push_cfg(M_RX, 1);
    mode = M_RX;
    pulse(1'b1, 1'b0);
    wait_locked("rx_lock_to", 500);
    tx_byte = 8'hFF; tx_valid = 1'b1;
    quiet_n = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_ready !== 1'b0 || data_mod !== 1'b0) quiet_n++;
    end
    check("rx_quiet", quiet_n, 0);
    fcw = 26'd12345;
    pulse(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("run_start_ign_busy", busy, 1'b0);
    check("run_start_ign_locked", locked, 1'b1);
    tx_valid = 1'b0;
    push_x(A_EN, 32'd0, 1'b1);
    pulse(1'b0, 1'b1);
    wait_done("rx_stop_to", 200);

    // Reset in the middle of a transfer.
    begin_test(1000, 0);
    push_x(A_FCW, 32'd12345, 1'b1);
    pulse(1'b1, 1'b0);
    wait_valid("rstx_valid_to", 20);
    rst = 1'b1;
    #1;
    check("rstx_valid", valid, 1'b0);
    sb.delete();
    check("rstx_busy", busy, 1'b0);
    check("rstx_address", address, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin_test(2, 1);
    fcw = 26'(FCW_CH); mode = M_TX;
    push_cfg(M_TX, 1);
    pulse(1'b1, 1'b0);
    wait_locked("rstx_relock_to", 500);
    check("rstx_relocked", locked, 1'b1);
    check("rstx_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
